bp_clint_responder: RTL and testbench

BP_CLINT_RESPONDER -- requirements
Module: bp_clint_responder

---
 rtl/bp_clint_responder.sv | 141 ++++++++++++++
 tb/tb_bp_clint_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bp_clint_responder.sv
// Core-local interruptor (mipi, mtimecmp, mtime) behind a one-outstanding
// request/response port; timer_irq_o tracks mtime >= mtimecmp.
module bp_clint_responder #(
  parameter int paddr_width_p = 40,
  parameter int data_width_p  = 64
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     timer_tick_i,
  input  logic                     req_v_i,
  output logic                     req_ready_o,
  input  logic                     req_w_i,
  input  logic [paddr_width_p-1:0] req_addr_i,
  input  logic [1:0]               req_size_i,
  input  logic [data_width_p-1:0]  req_data_i,
  output logic                     resp_v_o,
  input  logic                     resp_yumi_i,
  output logic [data_width_p-1:0]  resp_data_o,
  output logic                     resp_err_o,
  output logic                     software_irq_o,
  output logic                     timer_irq_o
);

  // Handshake: a request transfers on a rising edge where req_v_i & req_ready_o;
  // a response transfers on a rising edge where resp_v_o & resp_yumi_i.
  typedef enum logic {idle_s, resp_s} state_e;

  localparam logic [paddr_width_p-1:0] mipi_addr_lp     = paddr_width_p'(32'h0030_0000);
  localparam logic [paddr_width_p-1:0] mtimecmp_addr_lp = paddr_width_p'(32'h0030_4000);
  localparam logic [paddr_width_p-1:0] mtime_addr_lp    = paddr_width_p'(32'h0030_8000);

  state_e state_r, state_n;
  logic   mipi_r;
  logic [63:0] mtime_r, mtime_n;
  logic [63:0] mtimecmp_r, mtimecmp_n;
  logic   timer_irq_r;
  logic [data_width_p-1:0] resp_data_r;
  logic   resp_err_r;

  logic [paddr_width_p-1:0] word_addr;
  logic hit_mipi, hit_mtimecmp, hit_mtime, mapped;
  logic hi_sel, is_8b, size_ok, misaligned, err;
  logic accept, wr_ok;
  logic [63:0] rd_word, rd_data;
  logic [31:0] mtime_tick_lo;
  logic [63:0] mtime_inc;

  // Decode
  assign word_addr    = {req_addr_i[paddr_width_p-1:3], 3'b000};
  assign hit_mipi     = (word_addr == mipi_addr_lp);
  assign hit_mtimecmp = (word_addr == mtimecmp_addr_lp);
  assign hit_mtime    = (word_addr == mtime_addr_lp);
  assign mapped       = hit_mipi | hit_mtimecmp | hit_mtime;
  assign hi_sel       = req_addr_i[2];
  assign is_8b        = (req_size_i == 2'b11);
  assign size_ok      = req_size_i[1];
  assign misaligned   = (req_addr_i[1:0] != 2'b00) | (is_8b & hi_sel);
  assign err          = ~mapped | ~size_ok | misaligned | (hit_mipi & hi_sel);

  assign accept = (state_r == idle_s) & req_v_i;
  assign wr_ok  = accept & req_w_i & ~err;

  // FSM
  always_comb begin
    state_n     = state_r;
    req_ready_o = 1'b0;
    resp_v_o    = 1'b0;
    case (state_r)
      idle_s: begin
        req_ready_o = reset_n_i;
        if (req_v_i) state_n = resp_s;
      end
      resp_s: begin
        resp_v_o = 1'b1;
        if (resp_yumi_i) state_n = idle_s;
      end
      default: state_n = idle_s;
    endcase
  end

  // A half-word write to mtime blocks any tick carry across the 32-bit boundary.
  assign mtime_tick_lo = mtime_r[31:0] + 32'(timer_tick_i);
  assign mtime_inc     = mtime_r + 64'(timer_tick_i);

  always_comb begin
    mtime_n = mtime_inc;
    if (wr_ok && hit_mtime) begin
      if (is_8b)       mtime_n = req_data_i[63:0];
      else if (hi_sel) mtime_n = {req_data_i[31:0], mtime_tick_lo};
      else             mtime_n = {mtime_r[63:32], req_data_i[31:0]};
    end
  end

  always_comb begin
    mtimecmp_n = mtimecmp_r;
    if (wr_ok && hit_mtimecmp) begin
      if (is_8b)       mtimecmp_n = req_data_i[63:0];
      else if (hi_sel) mtimecmp_n = {req_data_i[31:0], mtimecmp_r[31:0]};
      else             mtimecmp_n = {mtimecmp_r[63:32], req_data_i[31:0]};
    end
  end

  // Read data reflects register values before this edge's tick or write.
  always_comb begin
    rd_word = 64'd0;
    if (hit_mipi)          rd_word = {63'd0, mipi_r};
    else if (hit_mtimecmp) rd_word = mtimecmp_r;
    else if (hit_mtime)    rd_word = mtime_r;
    if (is_8b)       rd_data = rd_word;
    else if (hi_sel) rd_data = {32'd0, rd_word[63:32]};
    else             rd_data = {32'd0, rd_word[31:0]};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= idle_s;
      mipi_r      <= 1'b0;
      mtime_r     <= 64'd0;
      mtimecmp_r  <= '1;
      timer_irq_r <= 1'b0;
      resp_data_r <= '0;
      resp_err_r  <= 1'b0;
    end else begin
      state_r     <= state_n;
      mtime_r     <= mtime_n;
      mtimecmp_r  <= mtimecmp_n;
      timer_irq_r <= (mtime_n >= mtimecmp_n);
      if (wr_ok && hit_mipi) mipi_r <= req_data_i[0];
      if (accept) begin
        resp_err_r  <= err;
        resp_data_r <= (err || req_w_i) ? '0 : data_width_p'(rd_data);
      end
    end
  end

  assign resp_data_o    = resp_data_r;
  assign resp_err_o     = resp_err_r;
  assign software_irq_o = mipi_r;
  assign timer_irq_o    = timer_irq_r;

endmodule

// File: tb/tb_bp_clint_responder.sv
// Directed bench for bp_clint_responder: register access, error decode,
// timer interrupt, tick/write interaction and reset during a pending response.
module tb_bp_clint_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        timer_tick;
  logic        req_v;
  logic        req_ready;
  logic        req_w;
  logic [39:0] req_addr;
  logic [1:0]  req_size;
  logic [63:0] req_data;
  logic        resp_v;
  logic        resp_yumi;
  logic [63:0] resp_data;
  logic        resp_err;
  logic        software_irq;
  logic        timer_irq;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [39:0] mipi_a  = 40'h00_0030_0000;
  localparam logic [39:0] cmp_a   = 40'h00_0030_4000;
  localparam logic [39:0] mtime_a = 40'h00_0030_8000;
  localparam logic [63:0] all_f   = 64'hFFFF_FFFF_FFFF_FFFF;

  bp_clint_responder dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .timer_tick_i   (timer_tick),
    .req_v_i        (req_v),
    .req_ready_o    (req_ready),
    .req_w_i        (req_w),
    .req_addr_i     (req_addr),
    .req_size_i     (req_size),
    .req_data_i     (req_data),
    .resp_v_o       (resp_v),
    .resp_yumi_i    (resp_yumi),
    .resp_data_o    (resp_data),
    .resp_err_o     (resp_err),
    .software_irq_o (software_irq),
    .timer_irq_o    (timer_irq)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one request from a point just after a clock edge; returns just
  // after the accept edge with the response pending.
  task automatic issue(input logic w, input logic [39:0] addr, input logic [1:0] size,
                       input logic [63:0] data, input logic tick);
    int waits = 0;
    while (!req_ready && waits < 10) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!req_ready) check("ready_timeout", 64'(req_ready), 64'd1);
    req_v = 1'b1; req_w = w; req_addr = addr; req_size = size; req_data = data;
    timer_tick = tick;
    @(posedge clk); #1;
    req_v = 1'b0; req_w = 1'b0; req_data = 64'd0; timer_tick = 1'b0;
    check("resp_v_after_accept", 64'(resp_v), 64'd1);
  endtask

  task automatic take(output logic [63:0] d, output logic e);
    d = resp_data;
    e = resp_err;
    resp_yumi = 1'b1;
    @(posedge clk); #1;
    resp_yumi = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [39:0] addr, input logic [1:0] size,
                          input logic [63:0] exp_d, input logic exp_e);
    logic [63:0] d;
    logic        e;
    issue(1'b0, addr, size, 64'd0, 1'b0);
    take(d, e);
    check({tag, "_data"}, d, exp_d);
    check({tag, "_err"}, 64'(e), 64'(exp_e));
  endtask

  task automatic wr(input string tag, input logic [39:0] addr, input logic [1:0] size,
                    input logic [63:0] data, input logic tick, input logic exp_e);
    logic [63:0] d;
    logic        e;
    issue(1'b1, addr, size, data, tick);
    take(d, e);
    check({tag, "_wdata"}, d, 64'd0);
    check({tag, "_err"}, 64'(e), 64'(exp_e));
  endtask

  initial begin
    logic [63:0] d;
    logic        e;
    reset_n = 1'b0; timer_tick = 1'b0; req_v = 1'b0; req_w = 1'b0;
    req_addr = 40'd0; req_size = 2'b00; req_data = 64'd0; resp_yumi = 1'b0;

    // reset state
    #12;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_resp_v", 64'(resp_v), 64'd0);
    check("rst_resp_data", resp_data, 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_sw_irq", 64'(software_irq), 64'd0);
    check("rst_tm_irq", 64'(timer_irq), 64'd0);
    #11 reset_n = 1'b1;
    #1 check("ready_after_rst", 64'(req_ready), 64'd1);

    rd_check("rd_cmp_rst", cmp_a, 2'b11, all_f, 1'b0);
    rd_check("rd_mtime_rst", mtime_a, 2'b11, 64'd0, 1'b0);
    rd_check("rd_mipi_rst", mipi_a, 2'b11, 64'd0, 1'b0);

    // software interrupt
    issue(1'b1, mipi_a, 2'b11, 64'd1, 1'b0);
    check("sw_irq_at_accept", 64'(software_irq), 64'd1);
    take(d, e);
    check("mipi_wr_err", 64'(e), 64'd0);
    rd_check("rd_mipi", mipi_a, 2'b11, 64'd1, 1'b0);
    rd_check("rd_mipi_4b", mipi_a, 2'b10, 64'd1, 1'b0);

    // error cases, none of which may change state
    rd_check("rd_unmapped", 40'h00_0030_0100, 2'b11, 64'd0, 1'b1);
    rd_check("rd_size01", mtime_a, 2'b01, 64'd0, 1'b1);
    rd_check("rd_misalign", mtime_a + 40'd1, 2'b10, 64'd0, 1'b1);
    rd_check("rd_8b_hi", mtime_a + 40'd4, 2'b11, 64'd0, 1'b1);
    rd_check("rd_mipi_hi", mipi_a + 40'd4, 2'b10, 64'd0, 1'b1);
    wr("wr_mipi_hi", mipi_a + 40'd4, 2'b10, 64'd0, 1'b0, 1'b1);
    wr("wr_mtime_sz01", mtime_a, 2'b01, 64'h1234, 1'b0, 1'b1);
    wr("wr_cmp_unal", cmp_a + 40'd2, 2'b10, 64'h0, 1'b0, 1'b1);
    check("sw_irq_kept", 64'(software_irq), 64'd1);
    rd_check("rd_mtime_kept", mtime_a, 2'b11, 64'd0, 1'b0);
    rd_check("rd_cmp_kept", cmp_a, 2'b11, all_f, 1'b0);

    // mtime wrap
    wr("wr_mtime_ff", mtime_a, 2'b11, all_f, 1'b0, 1'b0);
    check("tm_irq_eq", 64'(timer_irq), 64'd1);
    timer_tick = 1'b1;
    @(posedge clk); #1;
    timer_tick = 1'b0;
    check("tm_irq_wrapped", 64'(timer_irq), 64'd0);
    rd_check("rd_mtime_wrap", mtime_a, 2'b11, 64'd0, 1'b0);

    // half writes of mtimecmp
    wr("wr_cmp_lo", cmp_a, 2'b10, 64'hAAAA_AAAA_1234_5678, 1'b0, 1'b0);
    rd_check("rd_cmp_merge", cmp_a, 2'b11, 64'hFFFF_FFFF_1234_5678, 1'b0);
    rd_check("rd_cmp_hi4", cmp_a + 40'd4, 2'b10, 64'h0000_0000_FFFF_FFFF, 1'b0);
    rd_check("rd_cmp_lo4", cmp_a, 2'b10, 64'h0000_0000_1234_5678, 1'b0);

    // high-half write of mtime coinciding with a tick
    wr("wr_mtime_5", mtime_a, 2'b11, 64'd5, 1'b0, 1'b0);
    wr("wr_mtime_hi", mtime_a + 40'd4, 2'b10, 64'h0000_0000_DEAD_BEEF, 1'b1, 1'b0);
    rd_check("rd_mtime_hi_tick", mtime_a, 2'b11, 64'hDEAD_BEEF_0000_0006, 1'b0);
    // low-half write with a tick: high half holds
    wr("wr_mtime_lo", mtime_a, 2'b10, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0);
    rd_check("rd_mtime_lo_tick", mtime_a, 2'b11, 64'hDEAD_BEEF_FFFF_FFFF, 1'b0);

    // timer interrupt threshold
    wr("wr_cmp_10", cmp_a, 2'b11, 64'h10, 1'b0, 1'b0);
    check("tm_irq_above", 64'(timer_irq), 64'd1);
    wr("wr_mtime_0", mtime_a, 2'b11, 64'd0, 1'b0, 1'b0);
    check("tm_irq_below", 64'(timer_irq), 64'd0);
    timer_tick = 1'b1;
    repeat (15) begin @(posedge clk); #1; end
    check("tm_irq_at_0f", 64'(timer_irq), 64'd0);
    @(posedge clk); #1;
    check("tm_irq_at_10", 64'(timer_irq), 64'd1);
    repeat (3) begin
      @(posedge clk); #1;
      check("tm_irq_hold", 64'(timer_irq), 64'd1);
    end
    timer_tick = 1'b0;
    rd_check("rd_mtime_13", mtime_a, 2'b11, 64'h13, 1'b0);

    // pending response held, then discarded by reset
    issue(1'b0, mtime_a, 2'b11, 64'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_resp_v", 64'(resp_v), 64'd1);
      check("hold_resp_data", resp_data, 64'h13);
      check("hold_ready", 64'(req_ready), 64'd0);
    end
    reset_n = 1'b0;
    #2;
    check("rst2_resp_v", 64'(resp_v), 64'd0);
    check("rst2_resp_data", resp_data, 64'd0);
    check("rst2_ready", 64'(req_ready), 64'd0);
    check("rst2_sw_irq", 64'(software_irq), 64'd0);
    check("rst2_tm_irq", 64'(timer_irq), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1 check("rst2_ready_up", 64'(req_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst2_no_resp", 64'(resp_v), 64'd0);
    end
    rd_check("rd_cmp_rst2", cmp_a, 2'b11, all_f, 1'b0);
    rd_check("rd_mtime_rst2", mtime_a, 2'b11, 64'd0, 1'b0);
    rd_check("rd_mipi_rst2", mipi_a, 2'b11, 64'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
